// File: rtl/stg_if.sv
// ============================================================================
// Module   : stg_if
// Brief    : Instruction-fetch stage: request FSM, one-entry hold buffer and
//            registered instruction latch with branch/flush/stall handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stg_if #(
    parameter int                   SIZE_ADDR = 32,
    parameter int                   SIZE_DATA = 32,
    parameter logic [SIZE_ADDR-1:0] RESET_PC  = '0
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    output logic                 ow_imem_req,
    output logic [SIZE_ADDR-1:0] ow_imem_addr,
    input  logic                 iw_imem_ack,
    input  logic [SIZE_DATA-1:0] iw_imem_data,
    input  logic                 iw_branch_taken,
    input  logic [SIZE_ADDR-1:0] iw_branch_pc,
    input  logic                 iw_flush,
    input  logic                 iw_stall,
    output logic [SIZE_ADDR-1:0] ow_pc,
    output logic [SIZE_DATA-1:0] ow_instr
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [SIZE_ADDR-1:0] C_ADDR_ONE = SIZE_ADDR'(1);

    state_t                 state_q, state_d;
    logic [SIZE_ADDR-1:0]   r_fetch_pc, fetch_pc_d;
    logic [SIZE_DATA-1:0]   buf_q, buf_d;
    logic [SIZE_ADDR-1:0]   drain_q, drain_d;
    logic [SIZE_ADDR-1:0]   pc_q, pc_d;
    logic [SIZE_DATA-1:0]   instr_q, instr_d;
    logic                   w_deliver;
    logic [SIZE_DATA-1:0]   w_dlv_data;

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q    <= ST_REQ;
            r_fetch_pc <= RESET_PC;
            buf_q      <= '0;
            drain_q    <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            r_fetch_pc <= fetch_pc_d;
            buf_q      <= buf_d;
            drain_q    <= drain_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = r_fetch_pc;
        buf_d        = buf_q;
        drain_d      = drain_q;
        w_deliver    = 1'b0;
        w_dlv_data   = iw_imem_data;
        ow_imem_req  = 1'b1;
        ow_imem_addr = r_fetch_pc;

        case (state_q)
            ST_REQ: begin
                if (iw_imem_ack) begin
                    if (iw_branch_taken) begin
                        fetch_pc_d = iw_branch_pc;
                    end else if (iw_flush) begin
                        fetch_pc_d = r_fetch_pc;
                    end else if (iw_stall) begin
                        buf_d   = iw_imem_data;
                        state_d = ST_HOLD;
                    end else begin
                        w_deliver  = 1'b1;
                        fetch_pc_d = r_fetch_pc + C_ADDR_ONE;
                    end
                end else if (iw_branch_taken) begin
                    // The in-flight request must still complete; remember it.
                    drain_d    = r_fetch_pc;
                    fetch_pc_d = iw_branch_pc;
                    state_d    = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                ow_imem_req = 1'b0;
                w_dlv_data  = buf_q;
                if (iw_branch_taken) begin
                    fetch_pc_d = iw_branch_pc;
                    state_d    = ST_REQ;
                end else if (iw_flush) begin
                    state_d = ST_REQ;
                end else if (!iw_stall) begin
                    w_deliver  = 1'b1;
                    fetch_pc_d = r_fetch_pc + C_ADDR_ONE;
                    state_d    = ST_REQ;
                end
            end
            ST_DRAIN: begin
                ow_imem_addr = drain_q;
                if (iw_branch_taken) begin
                    fetch_pc_d = iw_branch_pc;
                end else if (iw_imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (iw_flush) begin
            pc_d    = '0;
            instr_d = '0;
        end else if (iw_stall) begin
            pc_d    = pc_q;
            instr_d = instr_q;
        end else if (w_deliver) begin
            pc_d    = r_fetch_pc;
            instr_d = w_dlv_data;
        end else begin
            pc_d    = '0;
            instr_d = '0;
        end
    end

    assign ow_pc    = pc_q;
    assign ow_instr = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_stg_if.sv
// ============================================================================
// Module   : tb_stg_if
// Brief    : Self-checking bench for stg_if: directed scenarios plus random
//            traffic against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stg_if;

    logic        iw_clk;
    logic        iw_rst_n;
    logic        ow_imem_req;
    logic [7:0]  ow_imem_addr;
    logic        iw_imem_ack;
    logic [15:0] iw_imem_data;
    logic        iw_branch_taken;
    logic [7:0]  iw_branch_pc;
    logic        iw_flush;
    logic        iw_stall;
    logic [7:0]  ow_pc;
    logic [15:0] ow_instr;

    int n_checks = 0;
    int n_pass   = 0;

    stg_if #(
        .SIZE_ADDR (8),
        .SIZE_DATA (16),
        .RESET_PC  (8'h10)
    ) u_dut (
        .iw_clk          (iw_clk),
        .iw_rst_n        (iw_rst_n),
        .ow_imem_req     (ow_imem_req),
        .ow_imem_addr    (ow_imem_addr),
        .iw_imem_ack     (iw_imem_ack),
        .iw_imem_data    (iw_imem_data),
        .iw_branch_taken (iw_branch_taken),
        .iw_branch_pc    (iw_branch_pc),
        .iw_flush        (iw_flush),
        .iw_stall        (iw_stall),
        .ow_pc           (ow_pc),
        .ow_instr        (ow_instr)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    // Behavioural model: fetch pointer, pending-drain flag, held word queue.
    logic [7:0]  m_pc;
    logic        m_drain;
    logic [7:0]  m_drain_addr;
    logic [15:0] m_buf_q[$];
    logic [7:0]  m_out_pc;
    logic [15:0] m_out_instr;
    logic        m_req;
    logic [7:0]  m_addr;

    function automatic logic [15:0] mem(input logic [7:0] a);
        return {8'h00, a} + 16'h0100;
    endfunction

    task automatic model_reset();
        m_pc         = 8'h10;
        m_drain      = 1'b0;
        m_drain_addr = 8'h00;
        m_buf_q.delete();
        m_out_pc     = 8'h00;
        m_out_instr  = 16'h0000;
    endtask

    task automatic drive(input logic a, input logic s, input logic f,
                         input logic b, input logic [7:0] bpc);
        m_req           = (m_buf_q.size() == 0);
        m_addr          = m_drain ? m_drain_addr : m_pc;
        iw_imem_ack     = a & m_req;
        iw_imem_data    = mem(m_addr);
        iw_stall        = s;
        iw_flush        = f;
        iw_branch_taken = b;
        iw_branch_pc    = bpc;
        #1;
    endtask

    task automatic tick();
        logic        dlv;
        logic [7:0]  dpc;
        logic [15:0] ddat;
        dlv  = 1'b0;
        dpc  = m_pc;
        ddat = 16'h0000;
        if (m_buf_q.size() != 0) begin
            if (iw_branch_taken) begin
                m_buf_q.delete();
                m_pc = iw_branch_pc;
            end else if (iw_flush) begin
                m_buf_q.delete();
            end else if (!iw_stall) begin
                dlv  = 1'b1;
                ddat = m_buf_q[0];
                m_buf_q.delete();
                m_pc = m_pc + 8'd1;
            end
        end else if (m_drain) begin
            if (iw_branch_taken)  m_pc = iw_branch_pc;
            else if (iw_imem_ack) m_drain = 1'b0;
        end else if (iw_imem_ack) begin
            if (iw_branch_taken) m_pc = iw_branch_pc;
            else if (iw_flush) m_pc = m_pc;
            else if (iw_stall) m_buf_q.push_back(iw_imem_data);
            else begin
                dlv  = 1'b1;
                ddat = iw_imem_data;
                m_pc = m_pc + 8'd1;
            end
        end else if (iw_branch_taken) begin
            m_drain      = 1'b1;
            m_drain_addr = m_pc;
            m_pc         = iw_branch_pc;
        end
        if (iw_flush) begin
            m_out_pc = 8'h00; m_out_instr = 16'h0000;
        end else if (iw_stall) begin
            m_out_pc = m_out_pc;
        end else if (dlv) begin
            m_out_pc = dpc; m_out_instr = ddat;
        end else begin
            m_out_pc = 8'h00; m_out_instr = 16'h0000;
        end
        @(posedge iw_clk);
        #1;
    endtask

    task automatic do_reset();
        iw_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge iw_clk);
        #1;
        iw_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_pc !== 8'h00) $display("FAIL reset_pc got %h want 00", ow_pc); else n_pass++;
        n_checks++; if (ow_instr !== 16'h0) $display("FAIL reset_instr got %h want 0000", ow_instr); else n_pass++;
        n_checks++; if (ow_imem_req !== 1'b1) $display("FAIL reset_req got %b want 1", ow_imem_req); else n_pass++;
        n_checks++; if (ow_imem_addr !== 8'h10) $display("FAIL reset_addr got %h want 10", ow_imem_addr); else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            n_checks++; if (ow_imem_addr !== 8'(8'h10 + i)) $display("FAIL stream_addr got %h want %h", ow_imem_addr, 8'(8'h10 + i)); else n_pass++;
            tick();
            n_checks++; if (ow_pc !== 8'(8'h10 + i)) $display("FAIL stream_pc got %h want %h", ow_pc, 8'(8'h10 + i)); else n_pass++;
            n_checks++; if (ow_instr !== 16'(16'h110 + i)) $display("FAIL stream_instr got %h want %h", ow_instr, 16'(16'h110 + i)); else n_pass++;
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h1F); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_addr !== 8'h20) $display("FAIL stall_ackaddr got %h want 20", ow_imem_addr); else n_pass++;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, (k < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 8'h00);
            n_checks++; if (ow_imem_req !== 1'b0) $display("FAIL stall_req cycle %0d got %b want 0", k, ow_imem_req); else n_pass++;
            n_checks++; if (ow_pc !== 8'h1F || ow_instr !== 16'h011F) $display("FAIL stall_hold got %h/%h want 1f/011f", ow_pc, ow_instr); else n_pass++;
            tick();
        end
        n_checks++; if (ow_pc !== 8'h20 || ow_instr !== 16'h0120) $display("FAIL stall_release got %h/%h want 20/0120", ow_pc, ow_instr); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_req !== 1'b1 || ow_imem_addr !== 8'h21) $display("FAIL stall_next got %b/%h want 1/21", ow_imem_req, ow_imem_addr); else n_pass++;
        tick();
    endtask

    task automatic test_branch_wait();
        logic seen30;
        seen30 = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h30); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_addr !== 8'h30) $display("FAIL brw_wait1 got %h want 30", ow_imem_addr); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
        n_checks++; if (ow_imem_addr !== 8'h30) $display("FAIL brw_wait2 got %h want 30", ow_imem_addr); else n_pass++;
        tick(); seen30 |= (ow_pc == 8'h30);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_req !== 1'b1 || ow_imem_addr !== 8'h30) $display("FAIL brw_drain got %b/%h want 1/30", ow_imem_req, ow_imem_addr); else n_pass++;
        tick(); seen30 |= (ow_pc == 8'h30);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_addr !== 8'h30) $display("FAIL brw_drainack got %h want 30", ow_imem_addr); else n_pass++;
        tick(); seen30 |= (ow_pc == 8'h30);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_addr !== 8'h80) $display("FAIL brw_target got %h want 80", ow_imem_addr); else n_pass++;
        tick();
        n_checks++; if (ow_pc !== 8'h80 || ow_instr !== 16'h0180) $display("FAIL brw_deliver got %h/%h want 80/0180", ow_pc, ow_instr); else n_pass++;
        n_checks++; if (seen30 !== 1'b0) $display("FAIL brw_discard got 30 delivered want never"); else n_pass++;
    endtask

    task automatic test_flush_hold();
        int cnt;
        cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h40); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        n_checks++; if (ow_imem_req !== 1'b0) $display("FAIL fl_inhold got req %b want 0", ow_imem_req); else n_pass++;
        tick();
        n_checks++; if (ow_pc !== 8'h00 || ow_instr !== 16'h0) $display("FAIL fl_bubble got %h/%h want 00/0000", ow_pc, ow_instr); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_req !== 1'b1 || ow_imem_addr !== 8'h40) $display("FAIL fl_refetch got %b/%h want 1/40", ow_imem_req, ow_imem_addr); else n_pass++;
        tick(); if (ow_pc == 8'h40 && ow_instr == 16'h0140) cnt++;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
            if (ow_pc == 8'h40) cnt++;
        end
        n_checks++; if (cnt != 1) $display("FAIL fl_once got %0d deliveries want 1", cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        n_checks++; if (ow_pc !== 8'hFF || ow_instr !== 16'h01FF) $display("FAIL wrap_ff got %h/%h want ff/01ff", ow_pc, ow_instr); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_addr !== 8'h00) $display("FAIL wrap_addr got %h want 00", ow_imem_addr); else n_pass++;
        tick();
        n_checks++; if (ow_pc !== 8'h00 || ow_instr !== 16'h0100) $display("FAIL wrap_00 got %h/%h want 00/0100", ow_pc, ow_instr); else n_pass++;
    endtask

    task automatic test_reset_drain();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h90); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_pc !== 8'h01 || ow_imem_addr !== 8'h02) $display("FAIL rd_pre got %h/%h want 01/02", ow_pc, ow_imem_addr); else n_pass++;
        #3;
        iw_rst_n = 1'b0;
        #1;
        n_checks++; if (ow_pc !== 8'h00 || ow_instr !== 16'h0) $display("FAIL rd_async got %h/%h want 00/0000", ow_pc, ow_instr); else n_pass++;
        n_checks++; if (ow_imem_req !== 1'b1 || ow_imem_addr !== 8'h10) $display("FAIL rd_inreset got %b/%h want 1/10", ow_imem_req, ow_imem_addr); else n_pass++;
        repeat (2) @(posedge iw_clk);
        #1;
        iw_rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ow_imem_req !== 1'b1 || ow_imem_addr !== 8'h10) $display("FAIL rd_first got %b/%h want 1/10", ow_imem_req, ow_imem_addr); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic a, s, f, b;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(99, 0) < 70);
            s = ($urandom_range(99, 0) < 25);
            f = ($urandom_range(99, 0) < 6);
            b = ($urandom_range(99, 0) < 8);
            drive(a, s, f, b, 8'($urandom_range(255, 0)));
            n_checks++; if (ow_imem_req !== m_req) $display("FAIL rnd_req cyc %0d got %b want %b", i, ow_imem_req, m_req); else n_pass++;
            if (m_req) begin
                n_checks++; if (ow_imem_addr !== m_addr) $display("FAIL rnd_addr cyc %0d got %h want %h", i, ow_imem_addr, m_addr); else n_pass++;
            end
            tick();
            n_checks++; if (ow_pc !== m_out_pc) $display("FAIL rnd_pc cyc %0d got %h want %h", i, ow_pc, m_out_pc); else n_pass++;
            n_checks++; if (ow_instr !== m_out_instr) $display("FAIL rnd_instr cyc %0d got %h want %h", i, ow_instr, m_out_instr); else n_pass++;
        end
    endtask

    initial begin
        iw_rst_n        = 1'b0;
        iw_imem_ack     = 1'b0;
        iw_imem_data    = 16'h0;
        iw_branch_taken = 1'b0;
        iw_branch_pc    = 8'h0;
        iw_flush        = 1'b0;
        iw_stall        = 1'b0;
        model_reset();
        @(posedge iw_clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_branch_wait();
        test_flush_hold();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
